// File: rtl/step_accum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : step_accum_ctrl_pkg
//  Purpose  : Shared constants for the step accumulator run controller:
//             FSM state encoding and default parameter values.
//  Revision : 1.0 - initial release
// ============================================================================
package step_accum_ctrl_pkg;

  // FSM state encoding (1-bit, two states)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Default parameter values
  localparam int WIDTH_DEF  = 8;
  localparam int STEP_DEF   = 10;
  localparam int LIMIT_DEF  = 100;
  localparam int PERIOD_DEF = 10;

endpackage : step_accum_ctrl_pkg
`default_nettype wire

// File: rtl/step_accum_ctrl_period_tick.sv
`default_nettype none
// ============================================================================
//  Module   : period_tick
//  Purpose  : Period counter. Counts 0..PERIOD-1 while enabled and flags the
//             last count of each period so the parent can act on that edge.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             clr  - synchronous clear of the period counter
//             en   - count enable
//             tick - high while en=1 and the counter sits at PERIOD-1
//  Revision : 1.0 - initial release
// ============================================================================
module period_tick
  import step_accum_ctrl_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              c_CW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PERIOD - 1);

  logic [c_CW-1:0] r_pcnt;
  logic            w_at_last;

  assign w_at_last = (r_pcnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      if (w_at_last) r_pcnt <= '0;
      else           r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Combinational: the parent registers its own tick output on this edge.
  assign tick = en & w_at_last;

endmodule : period_tick
`default_nettype wire

// File: rtl/step_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : step_accum_ctrl
//  Purpose  : Run controller. After an accepted start, adds STEP to the
//             accumulator once every PERIOD cycles, saturating at LIMIT where
//             the run ends with a done pulse. An abort cancels the run at any
//             point and is acknowledged with a one-cycle abort_ack pulse.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous active-high reset
//             start     - run request (accepted only in IDLE without abort)
//             abort     - cancel request (honoured only in RUN)
//             busy      - high while running
//             acc       - accumulator value
//             tick      - 1-cycle pulse when acc updates
//             tgl_out   - toggles on each tick while running, 0 otherwise
//             done      - 1-cycle pulse when acc reaches LIMIT
//             abort_ack - 1-cycle pulse when an abort is honoured
//  Revision : 1.0 - initial release
// ============================================================================
module step_accum_ctrl
  import step_accum_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP   = STEP_DEF,
  parameter int LIMIT  = LIMIT_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] acc,
  output logic             tick,
  output logic             tgl_out,
  output logic             done,
  output logic             abort_ack
);

  // One extra bit so acc+STEP cannot wrap before the LIMIT compare.
  localparam logic [WIDTH:0]   c_STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   c_LIMIT_EXT = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] c_LIMIT     = WIDTH'(LIMIT);

  logic [0:0]       r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_acc;
  logic             r_tick;
  logic             r_tgl;
  logic             r_done;
  logic             r_abort_ack;

  logic             w_accept;
  logic             w_cancel;
  logic             w_pt_clr;
  logic             w_pt_en;
  logic             w_tick_edge;
  logic [WIDTH:0]   w_sum;

  assign w_accept = (r_state == ST_IDLE) & start & ~abort;
  assign w_cancel = (r_state == ST_RUN) & abort;

  // Abort suppresses counting on its edge so a coincident tick is dropped.
  assign w_pt_clr = w_accept | w_cancel;
  assign w_pt_en  = (r_state == ST_RUN) & ~abort;

  period_tick #(
    .PERIOD (PERIOD)
  ) u_period_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_pt_clr),
    .en   (w_pt_en),
    .tick (w_tick_edge)
  );

  assign w_sum = {1'b0, r_acc} + c_STEP_EXT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_tick      <= 1'b0;
      r_tgl       <= 1'b0;
      r_done      <= 1'b0;
      r_abort_ack <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_abort_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_acc   <= '0;
            r_tgl   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_abort_ack <= 1'b1;
            r_tgl       <= 1'b0;
          end else if (w_tick_edge) begin
            r_tick <= 1'b1;
            if (w_sum >= c_LIMIT_EXT) begin
              r_acc   <= c_LIMIT;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_tgl   <= 1'b0;
            end else begin
              r_acc <= w_sum[WIDTH-1:0];
              r_tgl <= ~r_tgl;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign acc       = r_acc;
  assign tick      = r_tick;
  assign tgl_out   = r_tgl;
  assign done      = r_done;
  assign abort_ack = r_abort_ack;

endmodule : step_accum_ctrl
`default_nettype wire

// File: tb/tb_step_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_accum_ctrl
//  Purpose  : Directed self-checking bench for step_accum_ctrl. Instance A
//             uses default parameters, instance B uses STEP=30.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       b_start = 1'b0, b_abort = 1'b0;

  logic       a_busy, a_tick, a_tgl, a_done, a_ack;
  logic [7:0] a_acc;
  logic       b_busy, b_tick, b_tgl, b_done, b_ack;
  logic [7:0] b_acc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  step_accum_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(a_busy), .acc(a_acc), .tick(a_tick), .tgl_out(a_tgl),
    .done(a_done), .abort_ack(a_ack)
  );

  step_accum_ctrl #(.WIDTH(8), .STEP(30), .LIMIT(100), .PERIOD(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .acc(b_acc), .tick(b_tick), .tgl_out(b_tgl),
    .done(b_done), .abort_ack(b_ack)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_busy, a_acc, a_tick, a_tgl, a_done, a_ack} !== 13'd0) begin
      failures++; $display("FAIL reset_a outputs=%b exp=0", {a_busy, a_acc, a_tick, a_tgl, a_done, a_ack});
    end
    checks++;
    if ({b_busy, b_acc, b_tick, b_tgl, b_done, b_ack} !== 13'd0) begin
      failures++; $display("FAIL reset_b outputs=%b exp=0", {b_busy, b_acc, b_tick, b_tgl, b_done, b_ack});
    end
    step(2);
    rst = 1'b0;
    step(1);
    checks++;
    if (a_busy !== 1'b0 || a_acc !== 8'd0) begin
      failures++; $display("FAIL reset_release busy=%b acc=%0d exp busy=0 acc=0", a_busy, a_acc);
    end
  endtask

  // Full default run: ticks every 10 cycles, acc 10..100, done on tick 10.
  task automatic test_full_run();
    logic [7:0] e_acc;
    logic       e_tgl;
    start = 1'b1; step(1); start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_acc !== 8'd0 || a_tgl !== 1'b0 || a_tick !== 1'b0) begin
      failures++; $display("FAIL run_start busy=%b acc=%0d tgl=%b tick=%b exp 1/0/0/0", a_busy, a_acc, a_tgl, a_tick);
    end
    e_acc = 8'd0;
    e_tgl = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      for (int c = 1; c <= 10; c++) begin
        step(1);
        if (c == 10) begin
          e_acc = (k * 10 > 100) ? 8'd100 : 8'(k * 10);
          e_tgl = (k == 10) ? 1'b0 : ~e_tgl;
        end
        checks++;
        if (a_tick !== (c == 10) || a_acc !== e_acc || a_tgl !== e_tgl) begin
          failures++;
          $display("FAIL run_k%0d_c%0d tick=%b acc=%0d tgl=%b exp tick=%b acc=%0d tgl=%b",
                   k, c, a_tick, a_acc, a_tgl, (c == 10), e_acc, e_tgl);
        end
        checks++;
        if (a_done !== (c == 10 && k == 10) || a_busy !== !(c == 10 && k == 10)) begin
          failures++;
          $display("FAIL run_done_k%0d_c%0d done=%b busy=%b", k, c, a_done, a_busy);
        end
      end
    end
    step(1);
    checks++;
    if (a_done !== 1'b0 || a_tick !== 1'b0 || a_busy !== 1'b0 || a_acc !== 8'd100 || a_tgl !== 1'b0) begin
      failures++; $display("FAIL run_after done=%b tick=%b busy=%b acc=%0d tgl=%b exp 0/0/0/100/0",
                           a_done, a_tick, a_busy, a_acc, a_tgl);
    end
  endtask

  // STEP=30: acc 30, 60, 90, then saturate at 100 with done on tick 4.
  task automatic test_step30();
    logic [7:0] e_acc;
    b_start = 1'b1; step(1); b_start = 1'b0;
    e_acc = 8'd0;
    for (int k = 1; k <= 4; k++) begin
      for (int c = 1; c <= 10; c++) begin
        step(1);
        if (c == 10) e_acc = (k * 30 > 100) ? 8'd100 : 8'(k * 30);
        checks++;
        if (b_tick !== (c == 10) || b_acc !== e_acc || b_done !== (c == 10 && k == 4)) begin
          failures++;
          $display("FAIL step30_k%0d_c%0d tick=%b acc=%0d done=%b exp tick=%b acc=%0d done=%b",
                   k, c, b_tick, b_acc, b_done, (c == 10), e_acc, (c == 10 && k == 4));
        end
      end
    end
    step(1);
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_acc !== 8'd100) begin
      failures++; $display("FAIL step30_after busy=%b done=%b acc=%0d exp 0/0/100", b_busy, b_done, b_acc);
    end
  endtask

  // Abort mid-period after three ticks.
  task automatic test_abort_mid();
    start = 1'b1; step(1); start = 1'b0;
    step(32);
    checks++;
    if (a_acc !== 8'd30 || a_busy !== 1'b1) begin
      failures++; $display("FAIL abort_mid_pre acc=%0d busy=%b exp 30/1", a_acc, a_busy);
    end
    abort = 1'b1; step(1); abort = 1'b0;
    checks++;
    if (a_ack !== 1'b1 || a_busy !== 1'b0 || a_acc !== 8'd30 || a_tgl !== 1'b0 || a_tick !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL abort_mid ack=%b busy=%b acc=%0d tgl=%b tick=%b done=%b exp 1/0/30/0/0/0",
                           a_ack, a_busy, a_acc, a_tgl, a_tick, a_done);
    end
    step(1);
    checks++;
    if (a_ack !== 1'b0) begin
      failures++; $display("FAIL abort_mid_pulse ack=%b exp 0", a_ack);
    end
    for (int c = 0; c < 25; c++) begin
      step(1);
      checks++;
      if (a_tick !== 1'b0 || a_acc !== 8'd30 || a_busy !== 1'b0) begin
        failures++; $display("FAIL abort_mid_hold_c%0d tick=%b acc=%0d busy=%b exp 0/30/0", c, a_tick, a_acc, a_busy);
      end
    end
    start = 1'b1; step(1); start = 1'b0;
    checks++;
    if (a_acc !== 8'd0 || a_busy !== 1'b1) begin
      failures++; $display("FAIL abort_mid_restart acc=%0d busy=%b exp 0/1", a_acc, a_busy);
    end
    abort = 1'b1; step(1); abort = 1'b0;
    checks++;
    if (a_ack !== 1'b1 || a_busy !== 1'b0) begin
      failures++; $display("FAIL abort_mid_cleanup ack=%b busy=%b exp 1/0", a_ack, a_busy);
    end
    step(1);
  endtask

  // Abort coinciding with the 5th tick edge while acc=40.
  task automatic test_abort_on_tick();
    start = 1'b1; step(1); start = 1'b0;
    step(40);
    checks++;
    if (a_acc !== 8'd40 || a_tick !== 1'b1) begin
      failures++; $display("FAIL abort_tick_pre acc=%0d tick=%b exp 40/1", a_acc, a_tick);
    end
    step(9);
    abort = 1'b1; step(1); abort = 1'b0;
    checks++;
    if (a_acc !== 8'd40 || a_tick !== 1'b0 || a_done !== 1'b0 || a_ack !== 1'b1 || a_busy !== 1'b0 || a_tgl !== 1'b0) begin
      failures++; $display("FAIL abort_tick acc=%0d tick=%b done=%b ack=%b busy=%b tgl=%b exp 40/0/0/1/0/0",
                           a_acc, a_tick, a_done, a_ack, a_busy, a_tgl);
    end
    step(1);
    checks++;
    if (a_ack !== 1'b0 || a_acc !== 8'd40) begin
      failures++; $display("FAIL abort_tick_after ack=%b acc=%0d exp 0/40", a_ack, a_acc);
    end
  endtask

  // start+abort in IDLE, abort in IDLE, and start held during RUN.
  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_ack !== 1'b0 || a_acc !== 8'd40) begin
      failures++; $display("FAIL idle_start_abort busy=%b ack=%b acc=%0d exp 0/0/40", a_busy, a_ack, a_acc);
    end
    step(1); abort = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_ack !== 1'b0) begin
      failures++; $display("FAIL idle_abort busy=%b ack=%b exp 0/0", a_busy, a_ack);
    end
    start = 1'b1; step(1);
    checks++;
    if (a_busy !== 1'b1 || a_acc !== 8'd0) begin
      failures++; $display("FAIL held_start_begin busy=%b acc=%0d exp 1/0", a_busy, a_acc);
    end
    step(9);
    checks++;
    if (a_tick !== 1'b0 || a_acc !== 8'd0) begin
      failures++; $display("FAIL held_start_c9 tick=%b acc=%0d exp 0/0", a_tick, a_acc);
    end
    step(1);
    checks++;
    if (a_tick !== 1'b1 || a_acc !== 8'd10 || a_busy !== 1'b1) begin
      failures++; $display("FAIL held_start_t1 tick=%b acc=%0d busy=%b exp 1/10/1", a_tick, a_acc, a_busy);
    end
    step(10);
    checks++;
    if (a_tick !== 1'b1 || a_acc !== 8'd20 || a_tgl !== 1'b0) begin
      failures++; $display("FAIL held_start_t2 tick=%b acc=%0d tgl=%b exp 1/20/0", a_tick, a_acc, a_tgl);
    end
    abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    checks++;
    if (a_ack !== 1'b1 || a_busy !== 1'b0 || a_acc !== 8'd20) begin
      failures++; $display("FAIL held_start_abort ack=%b busy=%b acc=%0d exp 1/0/20", a_ack, a_busy, a_acc);
    end
    step(1);
    checks++;
    if (a_ack !== 1'b0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL held_start_idle ack=%b busy=%b exp 0/0", a_ack, a_busy);
    end
  endtask

  // Asynchronous reset mid-run at acc=70, then a full fresh run.
  task automatic test_async_reset();
    start = 1'b1; step(1); start = 1'b0;
    step(70);
    checks++;
    if (a_acc !== 8'd70 || a_busy !== 1'b1) begin
      failures++; $display("FAIL areset_pre acc=%0d busy=%b exp 70/1", a_acc, a_busy);
    end
    step(3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_acc, a_tick, a_tgl, a_done, a_ack} !== 13'd0) begin
      failures++; $display("FAIL areset_mid outputs=%b exp 0", {a_busy, a_acc, a_tick, a_tgl, a_done, a_ack});
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      checks++;
      if (a_done !== 1'b0 || a_ack !== 1'b0 || a_busy !== 1'b0 || a_tick !== 1'b0) begin
        failures++; $display("FAIL areset_after_c%0d done=%b ack=%b busy=%b tick=%b exp 0", c, a_done, a_ack, a_busy, a_tick);
      end
    end
    test_full_run();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_step30();
    test_abort_mid();
    test_abort_on_tick();
    test_start_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_step_accum_ctrl
`default_nettype wire

// File: doc/step_accum_ctrl.md
Name: step_accum_ctrl

Overview:
- Synthesizable run controller that accumulates a fixed STEP once per PERIOD clock cycles until LIMIT is reached.
- While running it drives a divided toggle output as a clock-enable style waveform.
- A named-abort request cancels a run at any point, and the block acknowledges the cancellation.
- Used by testbench-side sequencers and stop-flag logic to start, observe and cancel timed counting runs.

Parameters:
- WIDTH, 8, accumulator width in bits.
- STEP, 10, increment added per tick.
- LIMIT, 100, terminal accumulator value. Requires LIMIT < 2**WIDTH and STEP >= 1.
- PERIOD, 10, clock cycles per tick. Requires PERIOD >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled each cycle.
- abort  in  1  cancel request, sampled each cycle.
- busy  out  1  high while state is RUN.
- acc  out  WIDTH  accumulator value.
- tick  out  1  1-cycle pulse on the cycle acc updates.
- tgl_out  out  1  toggles on each tick while running; 0 otherwise.
- done  out  1  1-cycle pulse when acc reaches LIMIT.
- abort_ack  out  1  1-cycle pulse when an abort is honoured.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, busy=0, acc=0, tick=0, tgl_out=0, done=0, abort_ack=0, period counter pcnt=0.
- States:
  - IDLE: waits for a request.
  - RUN: counting.
- IDLE -> RUN: when start=1 and abort=0 at a rising edge. Same edge: acc<=0, pcnt<=0, tgl_out<=0, busy<=1.
- In RUN, pcnt counts 0..PERIOD-1. When pcnt==PERIOD-1 (tick edge):
  - pcnt<=0, tick<=1, tgl_out<=~tgl_out.
  - sum is computed WIDTH+1 bits wide as acc+STEP.
  - If sum >= LIMIT: acc<=LIMIT (saturate), done<=1, state<=IDLE, busy<=0, tgl_out<=0.
  - Otherwise: acc<=sum.
- First tick occurs PERIOD cycles after the start edge. The run ends after ceil(LIMIT/STEP) ticks.
- RUN -> IDLE on abort: abort=1 in RUN gives state<=IDLE, busy<=0, abort_ack<=1, tgl_out<=0, pcnt<=0. acc holds its last value.
- Simultaneous events:
  - abort and tick edge together: abort wins. There is no acc update, no tick and no done.
  - start and abort together in IDLE: nothing happens and abort_ack=0.
  - start in RUN: ignored, and the run is not restarted.
  - abort in IDLE: ignored and abort_ack=0.
- After done or abort, acc holds its value until the next accepted start clears it to 0.
- Reset asserted mid-run forces all reset values immediately. No done or abort_ack is emitted.
- tick, done and abort_ack are never high for more than one cycle. done and abort_ack are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1.
  - default parameter constants STEP_DEF, LIMIT_DEF and PERIOD_DEF.
- One sub-module, period_tick:
  - inputs: clk, rst, clr, en.
  - output: tick pulse, produced when pcnt==PERIOD-1.
  - parameter: PERIOD.
- The parent holds the FSM, the accumulator and the output registers.

Test Plan:
- Defaults; start pulsed at cycle 5 -> busy=1 from cycle 6. tick at cycles 15, 25, …, 105. acc steps 10, 20, …, 100. done=1 exactly at cycle 105, then busy=0. tgl_out toggles 9 times and returns to 0.
- STEP=30, LIMIT=100 -> acc sequence 30, 60, 90, then 100 (saturated) on the 4th tick with done. acc never exceeds 100.
- abort at RUN cycle 37 (acc=30) -> abort_ack 1 cycle, busy=0, acc stays 30, tgl_out=0, no further ticks. Next start clears acc to 0.
- abort exactly on a tick edge while acc=40 -> acc stays 40, tick=0, done=0, abort_ack=1.
- start held high during RUN, and start+abort together in IDLE -> no restart, no state change, abort_ack stays 0.
- rst asserted asynchronously mid-cycle during RUN (acc=70) -> all outputs 0 before the next edge. No done or abort_ack. A fresh start then runs a full 10-tick sequence.
